// File: rtl/register_pkg.sv
// Shared definitions for the serial link receiver: default word width,
// FSM state encoding and reset values for the parallel output.
package register_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rx_state_e;

   localparam logic [DEFAULT_WIDTH-1:0] PD_OUT_RST = 4'b0000;

endpackage : register_pkg

// File: rtl/bit_counter.sv
// Bit position counter for the receiver: counts qualified bits, wraps to
// zero after the terminal count WIDTH-1, and supports a synchronous clear.
module bit_counter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic tc_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             tc_s;

   assign tc_s = (count_q == CNT_W'(WIDTH - 1));
   assign tc_o = tc_s;

   // Next count: clear wins over increment; the terminal count wraps to zero.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         if (tc_s) begin
            count_d = '0;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : bit_counter

// File: rtl/register_sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH bits (MSB first) into a
// held word with a valid/ack handshake and a sticky overrun flag.
module register_sipo_rx
   import register_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             d_in,
   input  logic             en,
   input  logic             clr,
   input  logic             ack,
   output logic [WIDTH-1:0] pd_out,
   output logic             valid,
   output logic             busy,
   output logic             overrun
);

   localparam logic [WIDTH-1:0] PD_RST = WIDTH'(PD_OUT_RST);

   rx_state_e        state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] pd_q, pd_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             shift_s;
   logic             tc_s;
   logic             complete_s;

   assign shift_s    = en && !clr;
   assign complete_s = shift_s && tc_s;

   bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk   (clk),
      .reset (reset),
      .inc_i (shift_s),
      .clr_i (clr),
      .tc_o  (tc_s)
   );

   // FSM next state; clr overrides any bit arriving on the same edge.
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = ST_IDLE;
      end else if (en) begin
         case (state_q)
            ST_IDLE:  state_d = ST_SHIFT;
            ST_SHIFT: state_d = tc_s ? ST_IDLE : ST_SHIFT;
            default:  state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Datapath and handshake next values.
   always_comb begin
      sr_d      = sr_q;
      pd_d      = pd_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (clr) begin
         sr_d = '0;
      end else if (shift_s) begin
         sr_d = {sr_q[WIDTH-2:0], d_in};
      end else begin
         sr_d = sr_q;
      end
      if (complete_s) begin
         pd_d    = {sr_q[WIDTH-2:0], d_in};
         valid_d = 1'b1;
      end else if (ack && valid_q) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      // An ack on the completion edge frees the slot, so no overrun then.
      if (clr) begin
         overrun_d = 1'b0;
      end else if (complete_s && valid_q && !ack) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         pd_q      <= PD_RST;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         pd_q      <= pd_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign pd_out  = pd_q;
   assign valid   = valid_q;
   assign busy    = (state_q == ST_SHIFT);
   assign overrun = overrun_q;

endmodule : register_sipo_rx

// File: tb/tb_register_sipo_rx.sv
// Self-checking bench for register_sipo_rx: directed vector table, a reset
// mid-word sequence, and randomized traffic against a queue-based model.
module tb_register_sipo_rx;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         d_in = 1'b0;
   logic         en = 1'b0;
   logic         clr = 1'b0;
   logic         ack = 1'b0;
   logic [W-1:0] pd_out;
   logic         valid;
   logic         busy;
   logic         overrun;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         en;
      logic         d;
      logic         clr;
      logic         ack;
      logic [W-1:0] pd;
      logic         valid;
      logic         busy;
      logic         ovr;
   } vec_t;

   vec_t vecs[$];

   // reference model state
   bit           m_bits[$];
   logic [W-1:0] m_pd;
   logic         m_valid;
   logic         m_ovr;

   register_sipo_rx #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .d_in    (d_in),
      .en      (en),
      .clr     (clr),
      .ack     (ack),
      .pd_out  (pd_out),
      .valid   (valid),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [W-1:0] pd, input logic v,
                            input logic b, input logic o);
      check({tag, ".pd_out"},  int'(pd_out),  int'(pd));
      check({tag, ".valid"},   int'(valid),   int'(v));
      check({tag, ".busy"},    int'(busy),    int'(b));
      check({tag, ".overrun"}, int'(overrun), int'(o));
   endtask

   task automatic drive(input logic e, input logic d, input logic c, input logic a);
      en = e; d_in = d; clr = c; ack = a;
      @(posedge clk);
      #1;
      en = 1'b0; d_in = 1'b0; clr = 1'b0; ack = 1'b0;
   endtask

   function automatic void add(input logic e, input logic d, input logic c, input logic a,
                               input logic [W-1:0] pd, input logic v, input logic b,
                               input logic o);
      vec_t r;
      r.en = e; r.d = d; r.clr = c; r.ack = a;
      r.pd = pd; r.valid = v; r.busy = b; r.ovr = o;
      vecs.push_back(r);
   endfunction

   function automatic void model_reset();
      m_bits.delete();
      m_pd = '0;
      m_valid = 1'b0;
      m_ovr = 1'b0;
   endfunction

   // One clock edge of the receiver as described behaviourally.
   function automatic void model_step(input logic e, input logic d, input logic c,
                                      input logic a);
      logic [W-1:0] word;
      bit done = 0;
      if (c) begin
         m_bits.delete();
         m_ovr = 1'b0;
      end else if (e) begin
         m_bits.push_back(d);
         if (m_bits.size() == W) begin
            word = '0;
            foreach (m_bits[i]) word = {word[W-2:0], m_bits[i]};
            if (m_valid && !a) m_ovr = 1'b1;
            m_pd = word;
            m_valid = 1'b1;
            m_bits.delete();
            done = 1;
         end
      end
      if (!done && a) m_valid = 1'b0;
   endfunction

   initial begin
      logic [W-1:0] w;
      logic e, d, c, a;

      // directed table (starts just after reset release)
      w = 4'hA;
      for (int i = W - 1; i >= 0; i--)
         add(1'b1, w[i], 1'b0, 1'b0, (i == 0) ? 4'hA : 4'h0, i == 0, i != 0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
      w = 4'h6;
      for (int i = W - 1; i >= 0; i--) begin
         add(1'b1, w[i], 1'b0, 1'b0, (i == 0) ? 4'h6 : 4'hA, i == 0, i != 0, 1'b0);
         if (i != 0)
            for (int g = 0; g < 3; g++)
               add(1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0);
      end
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
      w = 4'h3;
      for (int i = W - 1; i >= 0; i--)
         add(1'b1, w[i], 1'b0, 1'b0, (i == 0) ? 4'h3 : 4'h6, i == 0, i != 0, 1'b0);
      w = 4'hC;
      for (int i = W - 1; i >= 0; i--)
         add(1'b1, w[i], 1'b0, 1'b0, (i == 0) ? 4'hC : 4'h3, 1'b1, i != 0, i == 0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
      w = 4'h9;
      for (int i = W - 1; i >= 0; i--)
         add(1'b1, w[i], 1'b0, 1'b0, (i == 0) ? 4'h9 : 4'hC, i == 0, i != 0, 1'b0);
      w = 4'h5;
      for (int i = W - 1; i >= 0; i--)
         add(1'b1, w[i], 1'b0, i == 0, (i == 0) ? 4'h5 : 4'h9, 1'b1, i != 0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < W; i++)
         add(1'b1, 1'b1, 1'b0, 1'b0, (i == W - 1) ? 4'hF : 4'h5, i == W - 1, i != W - 1, 1'b0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      foreach (vecs[k]) begin
         drive(vecs[k].en, vecs[k].d, vecs[k].clr, vecs[k].ack);
         check_all($sformatf("vec%0d", k), vecs[k].pd, vecs[k].valid, vecs[k].busy,
                   vecs[k].ovr);
      end

      // reset mid-word: two bits in, asynchronous reset, then a fresh word
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("midword.busy", int'(busy), 1);
      #2 reset = 1'b0;
      #1;
      check_all("async_reset", 4'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      w = 4'hB;
      for (int i = W - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0, 1'b0);
      check_all("after_reset", 4'hB, 1'b1, 1'b0, 1'b0);

      // randomized traffic against the model
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      model_reset();
      m_pd = 4'hB;
      check_all("rand_start", m_pd, m_valid, 1'b0, m_ovr);
      for (int k = 0; k < 400; k++) begin
         e = ($urandom_range(0, 9) < 7);
         d = $urandom_range(0, 1);
         c = ($urandom_range(0, 19) == 0);
         a = ($urandom_range(0, 9) < 3);
         model_step(e, d, c, a);
         drive(e, d, c, a);
         check_all($sformatf("rand%0d", k), m_pd, m_valid, m_bits.size() != 0, m_ovr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_register_sipo_rx
